// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end that shares a single alu_top.
// Sequences start/done, holds operands and returns result or error with a watchdog.
module alu_req_arbiter #(
    parameter int TIMEOUT = 64,
    parameter int CNT_W   = 7
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [5:0]  req_op,
    input  logic [15:0] req_a,
    input  logic [15:0] req_b,
    output logic [1:0]  rsp_valid,
    input  logic [1:0]  rsp_ready,
    output logic [15:0] rsp_result,
    output logic        rsp_err,
    output logic        alu_start,
    output logic [2:0]  alu_op,
    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    input  logic [15:0] alu_result,
    input  logic        alu_done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_nextState;
    logic               r_rrPtr;
    logic               r_grant;
    logic [2:0]         r_op;
    logic [7:0]         r_a;
    logic [7:0]         r_b;
    logic [CNT_W-1:0]   r_wdCnt;
    logic [15:0]        r_result;
    logic               r_err;

    logic               w_doGrant;
    logic               w_grantIdx;
    logic [2:0]         w_reqOp;
    logic [7:0]         w_reqA;
    logic [7:0]         w_reqB;
    logic               w_timeout;
    logic               w_consume;

    // A lone requester wins outright; on a tie the round-robin pointer decides.
    always_comb begin
        w_grantIdx = 1'b0;
        case (req_valid)
            2'b01:   w_grantIdx = 1'b0;
            2'b10:   w_grantIdx = 1'b1;
            2'b11:   w_grantIdx = r_rrPtr;
            default: w_grantIdx = 1'b0;
        endcase
    end

    // Gating with reset keeps req_ready low while the block is held in reset.
    assign w_doGrant = reset && (r_state == S_IDLE) && (req_valid != 2'b00);
    assign w_reqOp   = w_grantIdx ? req_op[5:3]  : req_op[2:0];
    assign w_reqA    = w_grantIdx ? req_a[15:8]  : req_a[7:0];
    assign w_reqB    = w_grantIdx ? req_b[15:8]  : req_b[7:0];
    assign w_timeout = (r_wdCnt == CNT_W'(TIMEOUT - 1));
    assign w_consume = (r_state == S_RESP) && rsp_ready[r_grant];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_doGrant) begin
                    w_nextState = (w_reqOp == 3'b111) ? S_RESP : S_ISSUE;
                end
            end
            S_ISSUE: w_nextState = S_WAIT;
            S_WAIT: begin
                if (alu_done || w_timeout) begin
                    w_nextState = S_RESP;
                end
            end
            S_RESP: begin
                if (w_consume) begin
                    w_nextState = S_IDLE;
                end
            end
            default: w_nextState = S_IDLE;
        endcase
    end

    // Operand latch, watchdog and response capture; done takes priority over timeout.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rrPtr  <= 1'b0;
            r_grant  <= 1'b0;
            r_op     <= 3'd0;
            r_a      <= 8'd0;
            r_b      <= 8'd0;
            r_wdCnt  <= '0;
            r_result <= 16'd0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_doGrant) begin
                        r_grant <= w_grantIdx;
                        r_op    <= w_reqOp;
                        r_a     <= w_reqA;
                        r_b     <= w_reqB;
                        if (w_reqOp == 3'b111) begin
                            r_result <= 16'd0;
                            r_err    <= 1'b1;
                        end
                    end
                end
                S_ISSUE: r_wdCnt <= '0;
                S_WAIT: begin
                    if (alu_done) begin
                        r_result <= alu_result;
                        r_err    <= 1'b0;
                    end else if (w_timeout) begin
                        r_result <= 16'd0;
                        r_err    <= 1'b1;
                    end else begin
                        r_wdCnt <= r_wdCnt + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    if (w_consume) begin
                        r_rrPtr <= ~r_grant;
                    end
                end
                default: ;
            endcase
        end
    end

    assign req_ready  = w_doGrant ? (w_grantIdx ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_valid  = (r_state == S_RESP) ? (r_grant ? 2'b10 : 2'b01) : 2'b00;
    assign rsp_result = r_result;
    assign rsp_err    = r_err;
    assign alu_start  = (r_state == S_ISSUE);
    assign alu_op     = r_op;
    assign alu_a      = r_a;
    assign alu_b      = r_b;
    assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Bench for alu_req_arbiter: requesters and a behavioural ALU driven from here,
// expectations derived from grant/latency rules with a simple rr-pointer model.
module tb_alu_req_arbiter;

    localparam int TO = 8;

    logic        clk;
    logic        reset;
    logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
    logic [5:0]  req_op;
    logic [15:0] req_a, req_b, rsp_result, alu_result;
    logic        rsp_err, alu_start, alu_done, busy;
    logic [2:0]  alu_op;
    logic [7:0]  alu_a, alu_b;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int aluDelay = 1;
    bit aluHang = 0;
    bit rrModel = 0;

    alu_req_arbiter #(.TIMEOUT(TO), .CNT_W(7)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
        .req_a(req_a), .req_b(req_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_result(rsp_result), .rsp_err(rsp_err),
        .alu_start(alu_start), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_result(alu_result), .alu_done(alu_done), .busy(busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL global_timeout: simulation did not finish, got running want finished");
        $fatal(1, "[TB] global timeout");
    end

    function automatic logic [15:0] aluFn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] sa, sb;
        sa = {{8{a[7]}}, a};
        sb = {{8{b[7]}}, b};
        case (op)
            3'd0:    return sa + sb;
            3'd1:    return sa - sb;
            3'd2:    return sa * sb;
            3'd3:    return {8'h00, a & b};
            3'd4:    return {8'h00, a | b};
            3'd5:    return {8'h00, a ^ b};
            3'd6:    return {a, b};
            default: return 16'h0000;
        endcase
    endfunction

    function automatic bit expGrant(input logic [1:0] v, input bit rr);
        if (v == 2'b01) return 1'b0;
        if (v == 2'b10) return 1'b1;
        return rr;
    endfunction

    // Behavioural ALU: done k cycles after the start pulse, unless hung.
    initial begin
        bit pending;
        int cnt;
        logic [15:0] pendRes;
        pending = 0;
        cnt = 0;
        pendRes = 0;
        alu_done = 1'b0;
        alu_result = 16'h0;
        forever begin
            @(posedge clk);
            #1;
            if (alu_done) begin
                alu_done = 1'b0;
                alu_result = 16'h0;
            end
            if (pending) begin
                cnt--;
                if (cnt <= 0) begin
                    alu_done = 1'b1;
                    alu_result = pendRes;
                    pending = 0;
                end
            end
            if (alu_start && !aluHang) begin
                pending = 1;
                cnt = aluDelay;
                pendRes = aluFn(alu_op, alu_a, alu_b);
            end
        end
    end

    // Drives one transaction to completion and reports what was observed; no checking here.
    task automatic run_one(input int rspDelay, input bit keepValid,
                           output int g, output int tRdy, output int tStart, output int tRsp, output int tCons,
                           output logic [2:0] gOp, output logic [7:0] gA, output logic [7:0] gB,
                           output logic [2:0] stOp, output logic [7:0] stA, output logic [7:0] stB,
                           output logic [15:0] res, output logic err,
                           output int starts, output int protoErr, output bit timedOut);
        logic [1:0] oh;
        bit fin;
        g = 0; tRdy = -1; tStart = -1; tRsp = -1; tCons = -1;
        gOp = 0; gA = 0; gB = 0; stOp = 0; stA = 0; stB = 0;
        res = 0; err = 0; starts = 0; protoErr = 0; timedOut = 0;
        oh = 2'b01;
        fin = 0;
        for (int n = 0; n < 300 && !fin; n++) begin
            @(negedge clk);
            if (tRdy < 0) begin
                if (req_ready != 2'b00) begin
                    if (req_ready != 2'b01 && req_ready != 2'b10) protoErr++;
                    g = req_ready[1] ? 1 : 0;
                    oh = req_ready[1] ? 2'b10 : 2'b01;
                    tRdy = cyc;
                    gOp = req_op[g*3 +: 3];
                    gA = req_a[g*8 +: 8];
                    gB = req_b[g*8 +: 8];
                end
            end else begin
                if (req_ready != 2'b00) protoErr++;
                if (alu_start) begin
                    starts++;
                    tStart = cyc;
                    stOp = alu_op;
                    stA = alu_a;
                    stB = alu_b;
                end
                if (tStart >= 0 && (alu_op !== stOp || alu_a !== stA || alu_b !== stB)) protoErr++;
                if (tRsp < 0) begin
                    if (rsp_valid != 2'b00) begin
                        if (rsp_valid != oh) protoErr++;
                        tRsp = cyc;
                        res = rsp_result;
                        err = rsp_err;
                    end
                end else if (rsp_valid !== oh || rsp_result !== res || rsp_err !== err) begin
                    protoErr++;
                end
                if (tRsp >= 0 && cyc - tRsp >= rspDelay) begin
                    rsp_ready = oh;
                    tCons = cyc;
                    fin = 1;
                end else begin
                    rsp_ready = ~oh;
                end
            end
            @(posedge clk);
            #1;
            if (tRdy >= 0 && tRdy == cyc - 1) begin
                if (keepValid) begin
                    req_op[g*3 +: 3] = 3'($urandom_range(0, 6));
                    req_a[g*8 +: 8] = 8'($urandom);
                    req_b[g*8 +: 8] = 8'($urandom);
                end else begin
                    req_valid[g] = 1'b0;
                end
            end
            if (fin) rsp_ready = 2'b00;
        end
        rsp_ready = 2'b00;
        if (!fin) timedOut = 1;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        req_valid = 2'b11;
        #2 reset = 1'b0;
        @(negedge clk);
        total++;
        if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b, busy} !== 42'h0) begin
            bad++;
            $display("[TB] FAIL reset_outputs: got %h want 0", {req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b, busy});
        end
        req_valid = 2'b00;
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        total++;
        if (busy !== 1'b0 || req_ready !== 2'b00) begin
            bad++;
            $display("[TB] FAIL reset_idle: got busy=%b ready=%b want 0/00", busy, req_ready);
        end
        rrModel = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_single;
        int g, tRdy, tStart, tRsp, tCons, starts, pe;
        bit to;
        logic [2:0] gOp, stOp;
        logic [7:0] gA, gB, stA, stB;
        logic [15:0] res;
        logic err;
        aluDelay = 1;
        req_op = 6'b000_000;
        req_a = 16'h0005;
        req_b = 16'h00FD;
        req_valid = 2'b01;
        run_one(0, 0, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
        total++;
        if (to || g != 0 || tStart != tRdy + 1) begin
            bad++;
            $display("[TB] FAIL single_grant: got to=%0d g=%0d start=+%0d want 0/0/+1", to, g, tStart - tRdy);
        end
        total++;
        if (stA !== 8'h05 || stB !== 8'hFD || stOp !== 3'b000) begin
            bad++;
            $display("[TB] FAIL single_operands: got a=%h b=%h op=%b want 05/fd/000", stA, stB, stOp);
        end
        total++;
        if (res !== 16'h0002 || err !== 1'b0 || tRsp != tRdy + 3) begin
            bad++;
            $display("[TB] FAIL single_rsp: got res=%h err=%b lat=%0d want 0002/0/3", res, err, tRsp - tRdy);
        end
        total++;
        if (pe != 0 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL single_proto: got perr=%0d busy=%b want 0/0", pe, busy);
        end
        rrModel = ~g[0];
    endtask

    task automatic test_contention;
        int g, tRdy, tStart, tRsp, tCons, starts, pe;
        bit to, eg;
        logic [2:0] gOp, stOp;
        logic [7:0] gA, gB, stA, stB;
        logic [15:0] res;
        logic err;
        reset = 1'b0;
        @(posedge clk);
        #1 reset = 1'b1;
        rrModel = 0;
        aluDelay = 4;
        req_op = 6'b010_010;
        req_a = {8'h03, 8'hF9};
        req_b = {8'h0B, 8'h09};
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            eg = expGrant(req_valid, rrModel);
            run_one(0, 1, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
            total++;
            if (to || g != int'(eg)) begin
                bad++;
                $display("[TB] FAIL contention_grant%0d: got g=%0d to=%0d want g=%0d", i, g, to, eg);
            end
            total++;
            if (res !== aluFn(gOp, gA, gB) || err !== 1'b0 || tRsp != tRdy + 6 || pe != 0) begin
                bad++;
                $display("[TB] FAIL contention_rsp%0d: got res=%h err=%b lat=%0d perr=%0d want %h/0/6/0",
                         i, res, err, tRsp - tRdy, pe, aluFn(gOp, gA, gB));
            end
            if (i == 0) begin
                total++;
                if (res !== 16'hFFC1) begin
                    bad++;
                    $display("[TB] FAIL contention_mul: got %h want ffc1", res);
                end
            end
            rrModel = ~g[0];
        end
        req_valid = 2'b00;
    endtask

    task automatic test_invalid;
        int g, tRdy, tStart, tRsp, tCons, starts, pe;
        bit to;
        logic [2:0] gOp, stOp;
        logic [7:0] gA, gB, stA, stB;
        logic [15:0] res;
        logic err;
        req_op = 6'b111_000;
        req_a = 16'h1234;
        req_b = 16'h5678;
        req_valid = 2'b10;
        run_one(1, 0, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
        total++;
        if (to || g != 1 || starts != 0) begin
            bad++;
            $display("[TB] FAIL invalid_grant: got to=%0d g=%0d starts=%0d want 0/1/0", to, g, starts);
        end
        total++;
        if (res !== 16'h0000 || err !== 1'b1 || tRsp != tRdy + 1 || pe != 0) begin
            bad++;
            $display("[TB] FAIL invalid_rsp: got res=%h err=%b lat=%0d perr=%0d want 0000/1/1/0", res, err, tRsp - tRdy, pe);
        end
        rrModel = ~g[0];
    endtask

    task automatic test_hung;
        int g, tRdy, tStart, tRsp, tCons, starts, pe;
        bit to;
        logic [2:0] gOp, stOp;
        logic [7:0] gA, gB, stA, stB;
        logic [15:0] res;
        logic err;
        aluHang = 1;
        req_op = 6'b000_001;
        req_a = 16'h0022;
        req_b = 16'h0011;
        req_valid = 2'b01;
        run_one(0, 0, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
        aluHang = 0;
        total++;
        if (to || g != 0 || starts != 1 || tRsp != tRdy + 2 + TO) begin
            bad++;
            $display("[TB] FAIL hung_latency: got to=%0d g=%0d starts=%0d lat=%0d want 0/0/1/%0d", to, g, starts, tRsp - tRdy, 2 + TO);
        end
        total++;
        if (res !== 16'h0000 || err !== 1'b1) begin
            bad++;
            $display("[TB] FAIL hung_rsp: got res=%h err=%b want 0000/1", res, err);
        end
        rrModel = ~g[0];
        aluDelay = 2;
        req_op = 6'b000_000;
        req_a = 16'h0A00;
        req_b = 16'h1400;
        req_valid = 2'b10;
        run_one(0, 0, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
        total++;
        if (to || g != 1 || res !== 16'd30 || err !== 1'b0 || tRsp != tRdy + 4) begin
            bad++;
            $display("[TB] FAIL hung_recover: got to=%0d g=%0d res=%h err=%b lat=%0d want 0/1/001e/0/4", to, g, res, err, tRsp - tRdy);
        end
        rrModel = ~g[0];
    endtask

    task automatic test_back_to_back;
        int g, tRdy, tStart, tRsp, tCons, starts, pe;
        int g2, tRdy2, tStart2, tRsp2, tCons2, starts2, pe2;
        bit to, to2;
        logic [2:0] gOp, stOp, gOp2, stOp2;
        logic [7:0] gA, gB, stA, stB, gA2, gB2, stA2, stB2;
        logic [15:0] res, res2;
        logic err, err2;
        aluDelay = 3;
        req_op = 6'b000_011;
        req_a = {8'h00, 8'($urandom)};
        req_b = {8'h00, 8'($urandom)};
        req_valid = 2'b01;
        run_one(5, 1, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
        total++;
        if (to || g != 0 || pe != 0) begin
            bad++;
            $display("[TB] FAIL backpressure_stable: got to=%0d g=%0d perr=%0d want 0/0/0", to, g, pe);
        end
        total++;
        if (res !== aluFn(gOp, gA, gB) || err !== 1'b0 || tRsp != tRdy + 5) begin
            bad++;
            $display("[TB] FAIL backpressure_rsp: got res=%h err=%b lat=%0d want %h/0/5", res, err, tRsp - tRdy, aluFn(gOp, gA, gB));
        end
        rrModel = ~g[0];
        run_one(0, 0, g2, tRdy2, tStart2, tRsp2, tCons2, gOp2, gA2, gB2, stOp2, stA2, stB2, res2, err2, starts2, pe2, to2);
        total++;
        if (to2 || g2 != 0 || tRdy2 != tCons + 1) begin
            bad++;
            $display("[TB] FAIL back_to_back_grant: got to=%0d g=%0d gap=%0d want 0/0/1", to2, g2, tRdy2 - tCons);
        end
        rrModel = ~g2[0];
        req_valid = 2'b00;
    endtask

    task automatic test_reset_mid;
        int g, tRdy, tStart, tRsp, tCons, starts, pe, viol;
        bit to, got;
        logic [2:0] gOp, stOp;
        logic [7:0] gA, gB, stA, stB;
        logic [15:0] res;
        logic err;
        aluDelay = 6;
        req_op = 6'b000_000;
        req_a = 16'h0033;
        req_b = 16'h0044;
        req_valid = 2'b01;
        got = 0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (req_ready == 2'b01) begin
                got = 1;
                break;
            end
        end
        @(posedge clk);
        #1 req_valid = 2'b00;
        @(posedge clk);
        @(negedge clk);
        total++;
        if (!got || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL midreset_setup: got granted=%0d busy=%b want 1/1", got, busy);
        end
        #2 reset = 1'b0;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b, busy} !== 42'h0) begin
            bad++;
            $display("[TB] FAIL midreset_async: got %h want 0", {req_ready, rsp_valid, rsp_result, rsp_err, alu_start, alu_op, alu_a, alu_b, busy});
        end
        @(posedge clk);
        #1 reset = 1'b1;
        viol = 0;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (rsp_valid !== 2'b00 || busy !== 1'b0) viol++;
        end
        total++;
        if (viol != 0) begin
            bad++;
            $display("[TB] FAIL midreset_done_ignored: got %0d active cycles want 0", viol);
        end
        rrModel = 0;
        @(posedge clk);
        #1;
        aluDelay = 1;
        req_valid = 2'b11;
        run_one(0, 0, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
        total++;
        if (to || g != int'(expGrant(2'b11, rrModel))) begin
            bad++;
            $display("[TB] FAIL midreset_rr: got g=%0d to=%0d want g=0", g, to);
        end
        rrModel = ~g[0];
        req_valid = 2'b00;
    endtask

    task automatic test_random;
        int g, tRdy, tStart, tRsp, tCons, starts, pe, rd;
        bit to, eg;
        logic [2:0] gOp, stOp;
        logic [7:0] gA, gB, stA, stB;
        logic [15:0] res, er;
        logic err;
        for (int it = 0; it < 30; it++) begin
            for (int i = 0; i < 2; i++) begin
                if (!req_valid[i] && ($urandom_range(0, 9) < 6)) begin
                    req_op[i*3 +: 3] = ($urandom_range(0, 5) == 0) ? 3'b111 : 3'($urandom_range(0, 6));
                    req_a[i*8 +: 8] = 8'($urandom);
                    req_b[i*8 +: 8] = 8'($urandom);
                    req_valid[i] = 1'b1;
                end
            end
            if (req_valid == 2'b00) begin
                req_op[2:0] = 3'($urandom_range(0, 6));
                req_a[7:0] = 8'($urandom);
                req_b[7:0] = 8'($urandom);
                req_valid[0] = 1'b1;
            end
            aluDelay = $urandom_range(1, 5);
            rd = $urandom_range(0, 3);
            eg = expGrant(req_valid, rrModel);
            run_one(rd, 0, g, tRdy, tStart, tRsp, tCons, gOp, gA, gB, stOp, stA, stB, res, err, starts, pe, to);
            total++;
            if (to || g != int'(eg) || pe != 0) begin
                bad++;
                $display("[TB] FAIL random%0d_grant: got g=%0d to=%0d perr=%0d want g=%0d", it, g, to, pe, eg);
            end
            if (gOp == 3'b111) begin
                total++;
                if (res !== 16'h0 || err !== 1'b1 || starts != 0 || tRsp != tRdy + 1) begin
                    bad++;
                    $display("[TB] FAIL random%0d_invalid: got res=%h err=%b starts=%0d lat=%0d want 0000/1/0/1",
                             it, res, err, starts, tRsp - tRdy);
                end
            end else begin
                er = aluFn(gOp, gA, gB);
                total++;
                if (res !== er || err !== 1'b0 || starts != 1 || tStart != tRdy + 1 || tRsp != tRdy + 2 + aluDelay
                    || stA !== gA || stB !== gB || stOp !== gOp) begin
                    bad++;
                    $display("[TB] FAIL random%0d_op: got res=%h err=%b lat=%0d a=%h b=%h want %h/0/%0d a=%h b=%h",
                             it, res, err, tRsp - tRdy, stA, stB, er, 2 + aluDelay, gA, gB);
                end
            end
            rrModel = ~g[0];
        end
        req_valid = 2'b00;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 2'b00;
        req_op = 6'd0;
        req_a = 16'd0;
        req_b = 16'd0;
        rsp_ready = 2'b00;
        test_reset;
        test_single;
        test_contention;
        test_invalid;
        test_hung;
        test_back_to_back;
        test_reset_mid;
        test_random;
        repeat (3) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/alu_req_arbiter.md
Name: alu_req_arbiter

Overview:
Two-requester front end that shares one alu_top instance between independent clients. It accepts operation requests over valid/ready handshakes and grants them round-robin. It sequences the ALU start/done protocol and holds operands stable for the whole operation. It returns the 16-bit result (or an error) to the granted requester and guards against a hung ALU with a watchdog.

Parameters:
TIMEOUT, 64, max cycles spent in WAIT before the operation is aborted with error (legal range 2..127)
CNT_W, 7, watchdog counter width (must satisfy 2^CNT_W > TIMEOUT)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  asynchronous, active-low reset
req_valid  input  2  bit i = requester i presents a request
req_ready  output  2  bit i = request i accepted this cycle (one-cycle pulse)
req_op  input  6  {op1[2:0], op0[2:0]}, alu_top opcode encoding
req_a  input  16  {a1[7:0], a0[7:0]}, signed operand A
req_b  input  16  {b1[7:0], b0[7:0]}, signed operand B
rsp_valid  output  2  bit i = response for requester i is on rsp_result/rsp_err
rsp_ready  input  2  bit i = requester i consumes the response
rsp_result  output  16  result, qualified by rsp_valid
rsp_err  output  1  1 = invalid opcode or watchdog timeout, qualified by rsp_valid
alu_start  output  1  one-cycle start pulse to alu_top
alu_op  output  3  opcode to alu_top
alu_a  output  8  operand A to alu_top
alu_b  output  8  operand B to alu_top
alu_result  input  16  alu_top result
alu_done  input  1  alu_top completion
busy  output  1  high in every state except IDLE

Behaviour:
- Reset (asynchronous, reset=0): state IDLE; all outputs 0; rr pointer=0; watchdog counter=0; latched op/a/b=0.
- States: IDLE, ISSUE, WAIT, RESP. Exactly one transaction is in flight at a time.
- IDLE, no req_valid: stay in IDLE.
- IDLE, only one req_valid bit set: grant that requester.
- IDLE, both bits set: grant the requester at the rr pointer.
- On grant g, in the same cycle: req_ready[g]=1; latch op/a/b of g; record g.
  - Latched op=3'b111: go to RESP with result 0, err=1; no ALU issue.
  - Otherwise: go to ISSUE.
- Requesters hold valid and payload until ready. Deasserting req_valid before grant is allowed; the arbiter takes no action for that requester.
- ISSUE: alu_start=1 for exactly this cycle; watchdog counter cleared; go to WAIT.
- alu_op/alu_a/alu_b are driven from the latched registers and stay constant from ISSUE through the end of RESP. They are updated only on a new grant.
- WAIT: alu_done is sampled only in this state; alu_done during ISSUE is ignored.
  - alu_done=1: capture alu_result; err=0; go to RESP.
  - No done: counter increments. When counter == TIMEOUT-1 without done, capture result 0, err=1, go to RESP.
  - alu_done and timeout in the same cycle: done wins.
- RESP: rsp_valid[g]=1; rsp_result/rsp_err stable; the other rsp_valid bit is 0.
  - Hold until rsp_ready[g]=1. In that cycle: rr pointer = ~g; go to IDLE.
  - rsp_ready on the non-granted bit is ignored.
- New requests are accepted no earlier than the cycle after RESP completes (IDLE). No back-to-back overlap.
- Latency, valid op with ALU done k cycles after start:
  - req_ready at T, alu_start at T+1.
  - Earliest alu_done at T+2.
  - rsp_valid at T+2+k.
- Latency, invalid op: rsp_valid at T+1.
- Watchdog abort: rsp_valid at T+2+TIMEOUT. The ALU is not reset by this block; the integrator resets alu_top from the same reset net, inverted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs 0. An in-flight transaction is dropped with no response.
- Operand sign is passed through unchanged; no width conversion. The result is exactly alu_result[15:0].

Test Plan:
1. Single request: req0 op=000, a=5, b=-3; ALU model done after 1 cycle with 2 -> req_ready=01 at T, alu_start at T+1 with alu_a=5, alu_b=0xFD; rsp_valid=01 with rsp_result=0x0002, rsp_err=0; IDLE after rsp_ready=01.
2. Contention: both valid every cycle from reset, op=010, ALU done after 4 cycles -> grants alternate 0,1,0,1; each requester sees its own product. Check -7*9 = 0xFFC1.
3. Invalid opcode: req1 op=111 -> req_ready=10, no alu_start ever; rsp_valid=10 at next cycle with result 0, err=1.
4. Hung ALU: TIMEOUT=8, alu_done never asserted -> rsp_valid at T+10 with err=1, result 0; a following request is served normally.
5. Backpressure and stability: rsp_ready held low 5 cycles in RESP with a new req0 pending -> rsp_valid, result, alu_a/alu_b/alu_op constant; req_ready stays 0 until after the consume cycle.
6. Reset mid-WAIT: reset=0 for 1 cycle during WAIT -> all outputs 0 asynchronously, busy=0; a later alu_done is ignored; rr pointer back to 0 (requester 0 wins the next tie).
